// File: rtl/alu_slice_exec_if.sv
// Port bundle for the digit-serial execute unit: operation request, operands,
// registered result and the start/busy/done status.
interface alu_slice_exec_if #(
    parameter int WIDTH = 32
);
    // Handshake: in IDLE or DONE, start=1 at a rising edge accepts ALUControl/SrcA/SrcB
    // and begins an operation. busy is high while slices are processed, and start is ignored then.
    // done pulses for one cycle when ALUResult/Zero are valid. The outputs hold until the next done.
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output start, ALUControl, SrcA, SrcB,
        input  ALUResult, Zero, busy, done, dbg_state
    );

    modport slave (
        input  start, ALUControl, SrcA, SrcB,
        output ALUResult, Zero, busy, done, dbg_state
    );
endinterface

// File: rtl/alu_slice_exec.sv
// Digit-serial execute unit: ADD/SUB/SLT/SLTU/OR/AND evaluated SLICE bits per
// cycle, LSB slice first, with the carry held in a register between slices.
module alu_slice_exec #(
    parameter int WIDTH  = 32,
    parameter int SLICE  = 8,
    parameter int NSLICE = WIDTH / SLICE
) (
    input  logic             clk,
    input  logic             reset,
    alu_slice_exec_if.slave  bus
);
    localparam logic [3:0] AND_OP  = 4'b0000;
    localparam logic [3:0] OR_OP   = 4'b0001;
    localparam logic [3:0] ADD_OP  = 4'b0010;
    localparam logic [3:0] SUB_OP  = 4'b0110;
    localparam logic [3:0] SLT_OP  = 4'b0111;
    localparam logic [3:0] SLTU_OP = 4'b1000;
    localparam int         CW      = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((SLICE < 1) || (WIDTH % SLICE != 0) || (NSLICE != WIDTH / SLICE)) begin : g_cfg_err
            $error("alu_slice_exec: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_sh;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;

    logic             load, last;
    int               base;
    logic [SLICE-1:0] a_s, b_s, b_eff, slice_val;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] shadow_n, final_res;
    logic             ovf, lt;

    // Subtraction-based ops all run A + ~B with a carry-in of one.
    function automatic logic is_sub(input logic [3:0] op);
        return (op == SUB_OP) || (op == SLT_OP) || (op == SLTU_OP);
    endfunction

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE: if (bus.start) begin load = 1'b1; state_n = RUN; end
            RUN:  if (last) state_n = DONE;
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        last      = (cnt == CW'(NSLICE - 1));
        base      = int'(cnt) * SLICE;
        a_s       = a_q[base +: SLICE];
        b_s       = b_q[base +: SLICE];
        b_eff     = is_sub(op_q) ? ~b_s : b_s;
        sum       = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry};
        slice_val = '0;
        case (op_q)
            ADD_OP, SUB_OP, SLT_OP, SLTU_OP: slice_val = sum[SLICE-1:0];
            OR_OP:   slice_val = a_s | b_s;
            AND_OP:  slice_val = a_s & b_s;
            default: slice_val = '0;
        endcase
        shadow_n               = res_sh;
        shadow_n[base +: SLICE] = slice_val;

        // Comparisons are resolved from the fully assembled difference.
        ovf       = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (shadow_n[WIDTH-1] != a_q[WIDTH-1]);
        lt        = 1'b0;
        final_res = shadow_n;
        if (op_q == SLT_OP) begin
            lt        = shadow_n[WIDTH-1] ^ ovf;
            final_res = {{(WIDTH-1){1'b0}}, lt};
        end else if (op_q == SLTU_OP) begin
            lt        = ~sum[SLICE];
            final_res = {{(WIDTH-1){1'b0}}, lt};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_sh <= '0;
            res_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            state <= state_n;
            if (load) begin
                a_q    <= bus.SrcA;
                b_q    <= bus.SrcB;
                op_q   <= bus.ALUControl;
                cnt    <= '0;
                carry  <= is_sub(bus.ALUControl);
                res_sh <= '0;
            end else if (state == RUN) begin
                res_sh <= shadow_n;
                carry  <= sum[SLICE];
                if (last) begin
                    res_q  <= final_res;
                    zero_q <= (final_res == '0);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_alu_slice_exec.sv
// Directed bench for alu_slice_exec: vector table for each opcode plus
// hand-written reset-abort and back-to-back sequences.
module tb_alu_slice_exec;
  localparam int WIDTH = 32;
  localparam logic [3:0] AND_OP  = 4'b0000;
  localparam logic [3:0] OR_OP   = 4'b0001;
  localparam logic [3:0] ADD_OP  = 4'b0010;
  localparam logic [3:0] SUB_OP  = 4'b0110;
  localparam logic [3:0] SLT_OP  = 4'b0111;
  localparam logic [3:0] SLTU_OP = 4'b1000;
  localparam logic [3:0] NOP_OP  = 4'b1111;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        scramble;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  alu_slice_exec_if #(.WIDTH(WIDTH)) bus ();
  alu_slice_exec #(.WIDTH(WIDTH), .SLICE(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic scramble, output logic [31:0] res, output logic z,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus.ALUControl = op;
    bus.SrcA = a;
    bus.SrcB = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 99;
    bcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (scramble && n == 2) begin
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        bus.ALUControl = 4'($urandom_range(0, 15));
      end
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    res = bus.ALUResult;
    z = bus.Zero;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic z;
    int lat, bcnt, done_cnt;

    vecs[0]  = '{ADD_OP,  32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0};
    vecs[1]  = '{SUB_OP,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{ADD_OP,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3]  = '{SLT_OP,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4]  = '{SLTU_OP, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{SLT_OP,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{OR_OP,   32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0, 1'b1};
    vecs[7]  = '{AND_OP,  32'hF0F0_0000, 32'h0F0F_00FF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8]  = '{NOP_OP,  32'hDEAD_BEEF, 32'h0123_4567, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{SLTU_OP, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0};
    vecs[10] = '{SLT_OP,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[11] = '{SUB_OP,  32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b1};
    vecs[12] = '{ADD_OP,  32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0};

    // clock/reset
    reset = 1'b1;
    bus.start = 1'b0;
    bus.ALUControl = ADD_OP;
    bus.SrcA = '0;
    bus.SrcB = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    check("rst_result", bus.ALUResult, 32'd0);
    check("rst_zero", 32'(bus.Zero), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    // vector table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].scramble, res, z, lat, bcnt);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].zero));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd4);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d_hold", i), bus.ALUResult, vecs[i].res);
    end

    // reset mid-RUN, with start asserted alongside reset
    @(negedge clk);
    bus.ALUControl = ADD_OP;
    bus.SrcA = 32'h11;
    bus.SrcB = 32'h22;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    check("midrun_rst_state", 32'(bus.dbg_state), 32'd0);
    check("midrun_rst_result", bus.ALUResult, 32'd0);
    check("midrun_rst_zero", 32'(bus.Zero), 32'd1);
    check("midrun_rst_busy", 32'(bus.busy), 32'd0);
    check("midrun_rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(bus.dbg_state), 32'd0);
    run_op(ADD_OP, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, res, z, lat, bcnt);
    check("post_rst_result", res, 32'h0100_0000);
    check("post_rst_latency", 32'(lat), 32'd5);

    // back-to-back issue with start held high
    @(negedge clk);
    bus.ALUControl = ADD_OP;
    bus.SrcA = 32'd1;
    bus.SrcB = 32'd2;
    bus.start = 1'b1;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd7);
    @(posedge clk);
    #1;
    bus.ALUControl = SUB_OP;
    bus.SrcA = 32'd10;
    bus.SrcB = 32'd3;
    done_cnt = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        check("b2b_done_pos", 32'(n), 32'(5 * done_cnt));
        if (exp_q.size() > 0) begin
          check("b2b_result", bus.ALUResult, exp_q.pop_front());
        end else begin
          check("b2b_extra_done", 32'(n), 32'd0);
        end
      end
      if (n == 10) bus.start = 1'b0;
    end
    check("b2b_done_count", 32'(done_cnt), 32'd2);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_end_idle", 32'(bus.dbg_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_slice_exec.md
Name: alu_slice_exec

Overview:
- Area-reduced execute unit. Sits directly downstream of the ALU decoder and consumes its 4-bit ALUControl code together with the two source operands.
- Evaluates ADD, SUB, SLT, SLTU, OR and AND one SLICE-bit digit per cycle, least-significant slice first.
- Carry is held in a register between slices.
- Uses a start/busy/done handshake so the multi-cycle controller can stall while a result is produced.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits processed per cycle. WIDTH must be an integer multiple of SLICE; any other value is a configuration error.
- NSLICE, WIDTH/SLICE, derived slice count; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- ALUControl  in  4  operation code from the ALU decoder, using the shared ALU op definitions (ADD_OP, SUB_OP, SLT_OP, SLTU_OP, OR_OP, AND_OP, NOP_OP).
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  high when ALUResult == 0.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse when ALUResult/Zero become valid.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, ALUResult=0, Zero=1, busy=0, done=0, slice counter=0, carry=0. Reset wins over start in the same cycle and aborts any operation in progress.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: start=1 latches SrcA, SrcB and ALUControl into internal registers, clears the counter, and moves to RUN.
  - RUN: processes slice[cnt]. While cnt < NSLICE-1, increments cnt. When cnt == NSLICE-1, moves to DONE.
  - DONE: done=1 for exactly this one cycle. On start=1, relatch operands and go to RUN (back-to-back issue). Otherwise go to IDLE.
- Inputs are sampled only at the accepting edge. Later changes to SrcA, SrcB or ALUControl do not affect the operation in flight.
- busy = 1 exactly in RUN. start in RUN is ignored (no queuing).
- Latency: start sampled at edge t gives done=1 during the cycle after edge t+NSLICE, i.e. NSLICE+1 cycles. With defaults that is 5.
- Arithmetic:
  - SUB, SLT and SLTU use A + ~B with initial carry=1. ADD uses initial carry=0.
  - Slice carry-out is registered as the carry-in for the next slice.
- Logic: OR and AND are bitwise per slice. Carry is unused.
- Result assembly: slices are written into the result shadow register at bit positions [cnt*SLICE +: SLICE].
- SLT and SLTU are resolved after the final slice:
  - SLT: lt = diff[WIDTH-1] XOR overflow, where overflow = (A[msb] != B[msb]) & (diff[msb] != A[msb]).
  - SLTU: lt = ~final carry-out.
  - Result = {WIDTH-1 zeros, lt}.
- NOP_OP and any unlisted code: result 0, Zero=1. The FSM still runs the full NSLICE cycles.
- Output update: ALUResult and Zero update only on the RUN→DONE edge. They hold their values through IDLE and the next RUN until the next DONE.
- Zero is computed from the final assembled result, not from per-slice partials.
- Overflow and carry-out of ADD/SUB are discarded; results wrap modulo 2^WIDTH.

Test Plan:
- reset held 2 cycles mid-RUN → next cycle: state IDLE, ALUResult=0, Zero=1, busy=0, done=0. A start after reset completes normally.
- ADD_OP, A=0x00FF_FFFF, B=0x0000_0001 → done at cycle 5 after start. ALUResult=0x0100_0000 (carry crosses 3 slices), Zero=0. busy high for exactly 4 cycles.
- SUB_OP, A=B=0x1234_5678 → ALUResult=0, Zero=1. Then ADD_OP, A=0xFFFF_FFFF, B=1 → ALUResult=0 (wrap), Zero=1.
- SLT_OP, A=0x8000_0000, B=0x7FFF_FFFF → result 1. SLTU_OP with the same operands → result 0. SLT_OP, A=5, B=5 → 0.
- OR_OP, A=0xF0F0_0000, B=0x0F0F_00FF → 0xFFFF_00FF. AND_OP with the same operands → 0. Change SrcA/SrcB/ALUControl during RUN → result unaffected.
- Back-to-back: start held high continuously with ADD 1+2 then SUB 10-3 → done pulses every 5 cycles with results 3 then 7. start pulses during RUN are ignored.
